div_unit: RTL and testbench
===========================

# div_unit

Sequential 32-bit integer divider for the core's execute stage, covering RV32M DIV/DIVU/REM/REMU. It performs radix-2 restoring division, one quotient bit per cycle. Each trial subtraction uses a `cla_32_bit` adder (A + ~B + 1). A start/busy/done handshake lets the execute stage stall on `busy` and capture results on `done`.

## Interface
Parameters:
- WIDTH, 32, operand width; must equal the width of `word_t`.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a division; sampled only in IDLE.
- is_signed  in  1  1 = two's-complement operands (DIV/REM); 0 = unsigned (DIVU/REMU).
- dividend  in  word_t  numerator; sampled with `start`.
- divisor  in  word_t  denominator; sampled with `start`.
- busy  out  1  high from the cycle after `start` is accepted until `done`, inclusive.
- done  out  1  one-cycle pulse when `quotient` and `remainder` are valid.
- quotient  out  word_t  result; held until the next accepted `start`.
- remainder  out  word_t  result; held until the next accepted `start`.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE, on `start`:
  - Latch the magnitudes |dividend| and |divisor|. Magnitudes apply only when `is_signed`; otherwise latch the raw values.
  - Latch the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
  - Clear the partial remainder and the iteration counter; go to CALC.
- CALC runs 32 iterations, MSB first. Each iteration:
  - Shift {rem, dvd} left by 1.
  - Compute trial = rem − divisor through `cla_32_bit`, with `cout` used as not-borrow.
  - If `cout` = 1: rem = trial and the quotient bit is 1. Otherwise rem is unchanged and the quotient bit is 0.
  - After the counter reaches 31, go to FIX.
- FIX:
  - Negate the quotient if its sign flag is set; negate the remainder if its sign flag is set.
  - Apply special cases, which override the computed result:
    - Divisor = 0: quotient = 0xFFFFFFFF; remainder = original dividend (sign-unmodified), both signed and unsigned.
    - Signed overflow (dividend = 0x80000000, divisor = 0xFFFFFFFF, `is_signed`): quotient = 0x80000000, remainder = 0.
  - Register the outputs and go to DONE.
- DONE: assert `done` for one cycle, then go to IDLE.
- `start` while busy is ignored and not queued. `start` in the DONE cycle is also ignored.
- Reset, including mid-operation: FSM goes to IDLE, counter goes to 0, `busy`/`done`/`quotient`/`remainder` all go to 0. Any in-flight operation is discarded.

## Timing
- Fixed latency, independent of operand values and special cases:
  - `start` sampled high on edge k.
  - CALC occupies edges k+1..k+32.
  - FIX registers outputs on edge k+33.
  - `done` is high between edges k+33 and k+34.
- `busy` is high between edges k and k+34.
- Earliest next accepted `start` is edge k+35 (IDLE after DONE). Issue interval is 35 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Reset reset values: `busy` = 0, `done` = 0, `quotient` = 0, `remainder` = 0, state = IDLE.

## Structure
- Shared package `common_types_pkg` holds:
  - `word_t` (already present).
  - New: `div_state_t` enum {IDLE, CALC, FIX, DONE}.
  - New: `localparam DIV_ITERS = 32`.
- One sub-module instance: `cla_32_bit` for the trial subtraction. Drive `cin` = 1 and `b` = ~divisor; leave `pg`/`gg` unconnected.
- Counter is 5 bits, wrapping 31→0 on the CALC→FIX transition.

## Test plan
- Unsigned: dividend 100, divisor 7, `is_signed` 0 → `done` at k+33 with quotient 14, remainder 2; `busy` high for exactly 34 cycles.
- Signed: −7 / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Also 7 / −2 → quotient −3, remainder 1.
- Divide by zero: 0x12345678 / 0, run signed and unsigned → quotient 0xFFFFFFFF, remainder 0x12345678, same latency.
- Signed overflow: 0x80000000 / 0xFFFFFFFF, signed → quotient 0x80000000, remainder 0. Run unsigned → quotient 0, remainder 0x80000000.
- Handshake:
  - `start` re-pulsed at k+5 and at the `done` cycle → ignored; the first result is unchanged.
  - `start` at k+35 → accepted; the prior outputs are held until that edge.
- Reset mid-operation: assert `rst` asynchronously at k+10 → `busy`/`done`/outputs go to 0 immediately. A subsequent 9/3 → quotient 3, remainder 0 at the normal latency.

Source files
------------

// File: rtl/common_types_pkg.sv
// Types shared across the execute stage: the machine word and the divider's
// control-state encoding and iteration count.
package common_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  localparam int DIV_ITERS = 32;

endpackage

// File: rtl/cla_32_bit.sv
// 32-bit carry-lookahead adder built from eight 4-bit lookahead groups whose
// group generate/propagate signals ripple between groups.
module cla_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        pg,
  output logic        gg
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic group_c;
    logic bit_c;
    logic grp_g;
    logic grp_p;
    logic acc_g;
    logic acc_p;
    // NOTE: every variable gets a default before any conditional or loop use, so no latch is inferred.
    c       = '0;
    group_c = cin;
    acc_g   = 1'b0;
    acc_p   = 1'b1;
    for (int blk = 0; blk < 8; blk++) begin
      grp_p = &p[blk*4 +: 4];
      grp_g = g[blk*4+3]
            | (p[blk*4+3] & g[blk*4+2])
            | (p[blk*4+3] & p[blk*4+2] & g[blk*4+1])
            | (p[blk*4+3] & p[blk*4+2] & p[blk*4+1] & g[blk*4]);
      bit_c = group_c;
      for (int i = 0; i < 4; i++) begin
        c[blk*4+i] = bit_c;
        bit_c      = g[blk*4+i] | (p[blk*4+i] & bit_c);
      end
      group_c = grp_g | (grp_p & group_c);
      acc_g   = grp_g | (grp_p & acc_g);
      acc_p   = acc_p & grp_p;
    end
    cout = group_c;
    gg   = acc_g;
    pg   = acc_p;
  end

  assign sum = p ^ c;

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU: sign handling around
// an unsigned core that retires one quotient bit per cycle.
module div_unit
  import common_types_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  logic  is_signed,
  input  word_t dividend,
  input  word_t divisor,
  output logic  busy,
  output logic  done,
  output word_t quotient,
  output word_t remainder
);

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

  div_state_t       state;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] dividend_orig;
  logic             q_neg;
  logic             r_neg;
  logic             div_zero;
  logic             overflow;

  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH-1:0] trial;
  logic             no_borrow;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign rem_shift = {rem[WIDTH-2:0], dvd[WIDTH-1]};

  cla_32_bit u_trial_sub (
    .a    (rem_shift),
    .b    (~dsr),
    .cin  (1'b1),
    .sum  (trial),
    .cout (no_borrow),
    .pg   (),
    .gg   ()
  );

  // Special cases override the sign-corrected magnitudes.
  always_comb begin
    q_fix = q_neg ? (~dvd + 1'b1) : dvd;
    r_fix = r_neg ? (~rem + 1'b1) : rem;
    if (div_zero) begin
      q_fix = '1;
      r_fix = dividend_orig;
    end else if (overflow) begin
      q_fix = {1'b1, {(WIDTH-1){1'b0}}};
      r_fix = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too; they are few and this keeps every output deterministic.
      state         <= IDLE;
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      quotient      <= '0;
      remainder     <= '0;
      rem           <= '0;
      dvd           <= '0;
      dsr           <= '0;
      dividend_orig <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      div_zero      <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge state.
      case (state)
        IDLE: begin
          if (start) begin
            dvd           <= (is_signed && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
            dsr           <= (is_signed && divisor[WIDTH-1]) ? (~divisor + 1'b1) : divisor;
            q_neg         <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg         <= is_signed && dividend[WIDTH-1];
            dividend_orig <= dividend;
            div_zero      <= (divisor == '0);
            overflow      <= is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
            rem           <= '0;
            cnt           <= '0;
            busy          <= 1'b1;
            state         <= CALC;
          end
        end
        CALC: begin
          rem <= no_borrow ? trial : rem_shift;
          dvd <= {dvd[WIDTH-2:0], no_borrow};
          cnt <= cnt + 5'd1;
          if (cnt == LAST_ITER) begin
            state <= FIX;
          end
        end
        FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, busy window, sign rules, special
// cases, handshake filtering and asynchronous reset.
module tb_div_unit;
  import common_types_pkg::*;

  logic  clk;
  logic  rst;
  logic  start;
  logic  is_signed;
  word_t dividend;
  word_t divisor;
  logic  busy;
  logic  done;
  word_t quotient;
  word_t remainder;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is seen by exactly one rising edge (edge k).
  task automatic issue(input word_t a, input word_t b, input logic s);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Counts negedges until done is seen, bounded; busy_cnt includes the current negedge.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc      = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic run_div(input string tag, input word_t a, input word_t b, input logic s,
                         input word_t exp_q, input word_t exp_r);
    int cyc;
    int bcnt;
    @(negedge clk);
    issue(a, b, s);
    wait_done(cyc, bcnt);
    check({tag, "_latency"}, 32'(cyc), 32'd33);
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'd34);
    check({tag, "_q"}, quotient, exp_q);
    check({tag, "_r"}, remainder, exp_r);
    @(negedge clk);
    check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    int bcnt;
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_q", quotient, 32'd0);
    check("reset_r", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div("u_100_7",    32'd100,        32'd7,          1'b0, 32'd14,         32'd2);
    run_div("s_m7_2",     32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF);
    run_div("s_7_m2",     32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1);
    run_div("s_m100_m7",  32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,         32'hFFFFFFFE);
    run_div("u_m7_2",     32'hFFFFFFF9,   32'd2,          1'b0, 32'h7FFFFFFC,   32'd1);
    run_div("u_max_big",  32'hFFFFFFFF,   32'hFFFFFFFE,   1'b0, 32'd1,          32'd1);
    run_div("u_small_big",32'hFFFFFFFE,   32'hFFFFFFFF,   1'b0, 32'd0,          32'hFFFFFFFE);
    run_div("s_div0",     32'h12345678,   32'd0,          1'b1, 32'hFFFFFFFF,   32'h12345678);
    run_div("u_div0",     32'h12345678,   32'd0,          1'b0, 32'hFFFFFFFF,   32'h12345678);
    run_div("s_neg_div0", 32'h80000000,   32'd0,          1'b1, 32'hFFFFFFFF,   32'h80000000);
    run_div("s_ovf",      32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0);
    run_div("u_ovf",      32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000);

    // Reset mid-operation: outputs (currently 0 / 0x80000000) must clear at once.
    @(negedge clk);
    issue(32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_busy", {31'd0, busy}, 32'd0);
    check("rst_async_done", {31'd0, done}, 32'd0);
    check("rst_async_q", quotient, 32'd0);
    check("rst_async_r", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_div("after_rst_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

    // Handshake: re-pulses at k+5 and at the done cycle are dropped.
    @(negedge clk);
    issue(32'd100, 32'd7, 1'b0);
    repeat (4) @(negedge clk);
    issue(32'd50, 32'd5, 1'b0);
    wait_done(cyc, bcnt);
    check("hs_latency", 32'(cyc), 32'd28);
    check("hs_q", quotient, 32'd14);
    check("hs_r", remainder, 32'd2);
    issue(32'd1000, 32'd10, 1'b0);
    check("hs_done_start_busy", {31'd0, busy}, 32'd0);
    check("hs_done_start_q", quotient, 32'd14);
    issue(32'd9, 32'd3, 1'b0);
    check("hs_k35_busy", {31'd0, busy}, 32'd1);
    check("hs_k35_q_held", quotient, 32'd14);
    check("hs_k35_r_held", remainder, 32'd2);
    wait_done(cyc, bcnt);
    check("hs_k35_latency", 32'(cyc), 32'd33);
    check("hs_k35_q", quotient, 32'd3);
    check("hs_k35_r", remainder, 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
